// File: rtl/dmem_responder.sv
`timescale 1ns/1ps
// Data-memory responder for the single-cycle core: byte-lane RAM plus MMIO page
// (console TX FIFO, sticky TEST_STATUS, CYCLE_CNT). Define DMEM_WRITE_TRACE_EN for a write trace.
module dmem_responder #(
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [1:0]  MemSize,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        test_done,
  output logic        test_pass,
  output logic        bus_err
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned FW = $clog2(FIFO_DEPTH);
  localparam logic [31:0] RAM_BYTES = DEPTH * 4;
  localparam logic [FW:0] FIFO_FULL = (FW + 1)'(FIFO_DEPTH);

  logic [31:0]   ram [DEPTH];
  logic [7:0]    fifo [FIFO_DEPTH];
  logic [FW-1:0] wr_ptr, rd_ptr;
  logic [FW:0]   count;
  logic [31:0]   cycle_cnt;

  logic [AW-1:0] word_idx;
  logic ram_sel, mmio_page, con_sel, stat_sel, cyc_sel;
  logic misaligned, mapped, wr_ok, wr_err, pop, push, fifo_full;
  logic [3:0]  be;
  logic [31:0] lane_data;

  assign word_idx   = DataAdr[AW+1:2];
  assign ram_sel    = DataAdr < RAM_BYTES;
  assign mmio_page  = DataAdr[31:12] == MMIO_BASE[31:12];
  assign con_sel    = mmio_page && DataAdr[11:0] == 12'h000;
  assign stat_sel   = mmio_page && DataAdr[11:0] == 12'h004;
  assign cyc_sel    = mmio_page && DataAdr[11:0] == 12'h008;
  assign misaligned = (MemSize == 2'b01 && DataAdr[0]) || (MemSize[1] && DataAdr[1:0] != 2'b00);
  assign mapped     = ram_sel || con_sel || stat_sel || cyc_sel;
  assign wr_ok      = MemWrite && mapped && !misaligned;

  assign tx_valid  = count != '0;
  assign tx_data   = fifo[rd_ptr];
  assign fifo_full = count == FIFO_FULL;
  assign pop       = tx_valid && tx_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push      = wr_ok && con_sel && (!fifo_full || pop);
  assign wr_err    = MemWrite && (!mapped || misaligned || (con_sel && fifo_full && !pop));

  always_comb begin
    be        = '1;
    lane_data = WriteData;
    case (MemSize)
      2'b00: begin
        be        = 4'b0001 << DataAdr[1:0];
        lane_data = {4{WriteData[7:0]}};
      end
      2'b01: begin
        be        = DataAdr[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{WriteData[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_ok && ram_sel) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) ram[word_idx][8*i +: 8] <= lane_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= WriteData[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      cycle_cnt <= '0;
      test_done <= 1'b0;
      test_pass <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (wr_ok && stat_sel && !test_done) begin
        test_done <= 1'b1;
        test_pass <= WriteData == 32'd1;
      end
      if (wr_err) bus_err <= 1'b1;
    end
  end

  always_comb begin
    ReadData = '0;
    if (ram_sel)       ReadData = ram[word_idx];
    else if (con_sel)  ReadData = 32'(count);
    else if (stat_sel) ReadData = {30'b0, test_pass, test_done};
    else if (cyc_sel)  ReadData = cycle_cnt;
  end

`ifdef DMEM_WRITE_TRACE_EN
  always_ff @(posedge clk) begin
    if (!reset && MemWrite) begin
      if (wr_err) $display("%0t ns : BUS ERROR @ %0d", $time, DataAdr);
      else        $display("%0t ns : Write @ %0d = %0d", $time, DataAdr, WriteData);
    end
  end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
`timescale 1ns/1ps
// Bench for dmem_responder: directed vector table, hand sequences for FIFO/status/counter,
// then random traffic against a byte-addressed reference model.
module tb_dmem_responder;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned FD    = 8;
  localparam logic [31:0] CON  = 32'hFFFF_0000;
  localparam logic [31:0] STAT = 32'hFFFF_0004;
  localparam logic [31:0] CYC  = 32'hFFFF_0008;

  logic clk = 1'b0, reset = 1'b1;
  logic MemWrite = 1'b0, tx_ready = 1'b0;
  logic [1:0] MemSize = 2'b10;
  logic [31:0] DataAdr = '0, WriteData = '0;
  logic [31:0] ReadData;
  logic tx_valid, test_done, test_pass, bus_err;
  logic [7:0] tx_data;

  dmem_responder #(.DEPTH(DEPTH), .FIFO_DEPTH(FD), .MMIO_BASE(32'hFFFF_0000)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .MemSize(MemSize), .DataAdr(DataAdr),
    .WriteData(WriteData), .ReadData(ReadData), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .test_done(test_done), .test_pass(test_pass), .bus_err(bus_err));

  always #5 clk = ~clk;

  int unsigned passed = 0, total = 0;

  // Reference model
  logic [7:0]  mram [DEPTH*4];
  logic [7:0]  mq [$];
  logic        mdone, mpass, merr;
  logic [31:0] mcyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    logic [31:0] b;
    if (a < DEPTH*4) begin
      b = a & ~32'd3;
      return {mram[b+3], mram[b+2], mram[b+1], mram[b]};
    end
    if (a[31:12] == 20'hFFFF0) begin
      case (a[11:0])
        12'h000: return 32'(mq.size());
        12'h004: return {30'b0, mpass, mdone};
        12'h008: return mcyc;
        default: return '0;
      endcase
    end
    return '0;
  endfunction

  task automatic apply(input logic we, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input logic rdy);
    MemWrite = we; MemSize = sz; DataAdr = a; WriteData = wd; tx_ready = rdy;
    #1;
  endtask

  // Advance the model by one edge, then the DUT.
  task automatic tick();
    bit aligned, full, pop;
    int unsigned n;
    full = mq.size() >= FD;
    pop  = mq.size() > 0 && tx_ready;
    if (pop) void'(mq.pop_front());
    if (MemWrite) begin
      aligned = !((MemSize == 2'b01 && DataAdr[0]) || (MemSize[1] && DataAdr[1:0] != 2'b00));
      n = (MemSize == 2'b00) ? 1 : (MemSize == 2'b01) ? 2 : 4;
      if (!aligned) merr = 1'b1;
      else if (DataAdr < DEPTH*4) begin
        for (int unsigned i = 0; i < n; i++) mram[DataAdr+i] = WriteData[8*i +: 8];
      end else if (DataAdr[31:12] == 20'hFFFF0) begin
        case (DataAdr[11:0])
          12'h000: if (!full || pop) mq.push_back(WriteData[7:0]); else merr = 1'b1;
          12'h004: if (!mdone) begin mdone = 1'b1; mpass = (WriteData == 32'd1); end
          12'h008: ;
          default: merr = 1'b1;
        endcase
      end else merr = 1'b1;
    end
    mcyc++;
    @(posedge clk); #1;
  endtask

  task automatic rst(input int unsigned n);
    MemWrite = 1'b0; tx_ready = 1'b0; reset = 1'b1;
    repeat (n) @(posedge clk);
    #1 reset = 1'b0;
    mq.delete(); mdone = 1'b0; mpass = 1'b0; merr = 1'b0; mcyc = '0;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_rd"}, ReadData, model_rd(DataAdr));
    check({tag, "_txv"}, 32'(tx_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) check({tag, "_txd"}, 32'(tx_data), 32'(mq[0]));
    check({tag, "_err"}, 32'(bus_err), 32'(merr));
    check({tag, "_done"}, 32'(test_done), 32'(mdone));
    check({tag, "_pass"}, 32'(test_pass), 32'(mpass));
  endtask

  typedef struct {
    logic we; logic [1:0] sz; logic [31:0] adr; logic [31:0] wd;
    logic chk_rd; logic [31:0] rd; logic err;
  } vec_t;
  vec_t tbl [16];

  logic [31:0] a;
  int unsigned r;

  initial begin
    tbl[0]  = '{1'b1, 2'b10, 32'd100, 32'd7,          1'b0, 32'd0,          1'b0};
    tbl[1]  = '{1'b0, 2'b10, 32'd100, 32'd0,          1'b1, 32'd7,          1'b0};
    tbl[2]  = '{1'b1, 2'b10, 32'd96,  32'h1122_3344,  1'b0, 32'd0,          1'b0};
    tbl[3]  = '{1'b1, 2'b00, 32'd97,  32'h0000_00AA,  1'b0, 32'd0,          1'b0};
    tbl[4]  = '{1'b1, 2'b01, 32'd98,  32'h0000_BEEF,  1'b1, 32'h1122_AA44,  1'b0};
    tbl[5]  = '{1'b0, 2'b10, 32'd96,  32'd0,          1'b1, 32'hBEEF_AA44,  1'b0};
    tbl[6]  = '{1'b1, 2'b10, 32'd100, 32'h55,         1'b1, 32'd7,          1'b0};
    tbl[7]  = '{1'b0, 2'b10, 32'd100, 32'd0,          1'b1, 32'h55,         1'b0};
    tbl[8]  = '{1'b1, 2'b10, 32'd98,  32'hDEAD_BEEF,  1'b1, 32'hBEEF_AA44,  1'b0};
    tbl[9]  = '{1'b0, 2'b10, 32'd96,  32'd0,          1'b1, 32'hBEEF_AA44,  1'b1};
    tbl[10] = '{1'b1, 2'b10, 32'h1000, 32'h1234,      1'b1, 32'd0,          1'b1};
    tbl[11] = '{1'b0, 2'b10, 32'h1000, 32'd0,         1'b1, 32'd0,          1'b1};
    tbl[12] = '{1'b1, 2'b01, 32'd101, 32'hFFFF,       1'b1, 32'h55,         1'b1};
    tbl[13] = '{1'b0, 2'b10, 32'd100, 32'd0,          1'b1, 32'h55,         1'b1};
    tbl[14] = '{1'b0, 2'b10, 32'hFFFF_000C, 32'd0,    1'b1, 32'd0,          1'b1};
    tbl[15] = '{1'b0, 2'b10, CON,     32'd0,          1'b1, 32'd0,          1'b1};

    // Reset state
    rst(3);
    apply(1'b0, 2'b10, CYC, 32'd0, 1'b0);
    check("rst_cyc", ReadData, 32'd0);
    check("rst_txv", 32'(tx_valid), 32'd0);
    check("rst_err", 32'(bus_err), 32'd0);
    check("rst_done", 32'(test_done), 32'd0);

    // RAM stores, lanes, read-during-write, misaligned/unmapped errors
    for (int i = 0; i < 16; i++) begin
      apply(tbl[i].we, tbl[i].sz, tbl[i].adr, tbl[i].wd, 1'b0);
      if (tbl[i].chk_rd) check($sformatf("vec%0d_rd", i), ReadData, tbl[i].rd);
      check($sformatf("vec%0d_err", i), 32'(bus_err), 32'(tbl[i].err));
      check($sformatf("vec%0d_txv", i), 32'(tx_valid), 32'd0);
      tick();
    end

    // FIFO fill, overflow drop, drain
    rst(1);
    for (int i = 0; i < 8; i++) begin
      apply(1'b1, 2'b00, CON, 32'h41 + 32'(i), 1'b0);
      if (i == 0) check("fifo_empty_txv", 32'(tx_valid), 32'd0);
      tick();
      if (i == 0) begin
        check("fifo_first_txv", 32'(tx_valid), 32'd1);
        check("fifo_first_txd", 32'(tx_data), 32'h41);
      end
    end
    apply(1'b0, 2'b10, CON, 32'd0, 1'b0);
    check("fifo_count8", ReadData, 32'd8);
    check("fifo_noerr", 32'(bus_err), 32'd0);
    apply(1'b1, 2'b10, CON, 32'h49, 1'b0);
    tick();
    apply(1'b0, 2'b10, CON, 32'd0, 1'b0);
    check("fifo_ovf_err", 32'(bus_err), 32'd1);
    check("fifo_ovf_count", ReadData, 32'd8);
    for (int i = 0; i < 8; i++) begin
      apply(1'b0, 2'b10, 32'd0, 32'd0, 1'b1);
      check($sformatf("drain%0d_txv", i), 32'(tx_valid), 32'd1);
      check($sformatf("drain%0d_txd", i), 32'(tx_data), 32'h41 + 32'(i));
      tick();
    end
    apply(1'b0, 2'b10, CON, 32'd0, 1'b1);
    check("drain_done_txv", 32'(tx_valid), 32'd0);
    check("drain_done_count", ReadData, 32'd0);

    // Push into a full FIFO while the head pops
    rst(1);
    for (int i = 0; i < 8; i++) begin
      apply(1'b1, 2'b00, CON, 32'h41 + 32'(i), 1'b0);
      tick();
    end
    apply(1'b1, 2'b00, CON, 32'h5A, 1'b1);
    tick();
    apply(1'b0, 2'b10, CON, 32'd0, 1'b0);
    check("fullpush_count", ReadData, 32'd8);
    check("fullpush_err", 32'(bus_err), 32'd0);
    for (int i = 0; i < 8; i++) begin
      apply(1'b0, 2'b10, 32'd0, 32'd0, 1'b1);
      check($sformatf("fp_drain%0d", i), 32'(tx_data), (i == 7) ? 32'h5A : 32'h42 + 32'(i));
      tick();
    end

    // TEST_STATUS sticky, CYCLE_CNT, reset mid-run
    rst(1);
    apply(1'b1, 2'b10, STAT, 32'd1, 1'b0);
    check("stat_pre_done", 32'(test_done), 32'd0);
    tick();
    apply(1'b1, 2'b10, STAT, 32'd5, 1'b0);
    tick();
    apply(1'b0, 2'b10, STAT, 32'd0, 1'b0);
    check("stat_done", 32'(test_done), 32'd1);
    check("stat_pass", 32'(test_pass), 32'd1);
    check("stat_rd", ReadData, 32'd3);
    rst(2);
    apply(1'b1, 2'b10, STAT, 32'd5, 1'b0);
    tick();
    apply(1'b1, 2'b10, STAT, 32'd1, 1'b0);
    tick();
    apply(1'b0, 2'b10, STAT, 32'd0, 1'b0);
    check("statfail_rd", ReadData, 32'd1);
    rst(1);
    apply(1'b0, 2'b10, CYC, 32'd0, 1'b0);
    check("cyc_first", ReadData, 32'd0);
    repeat (10) tick();
    check("cyc_n", ReadData, 32'd10);
    apply(1'b1, 2'b00, CON, 32'h33, 1'b0); tick();
    apply(1'b1, 2'b10, 32'h2000, 32'd0, 1'b0); tick();
    apply(1'b1, 2'b10, STAT, 32'd1, 1'b0); tick();
    rst(1);
    apply(1'b0, 2'b10, CYC, 32'd0, 1'b0);
    check("midrst_txv", 32'(tx_valid), 32'd0);
    check("midrst_err", 32'(bus_err), 32'd0);
    check("midrst_done", 32'(test_done), 32'd0);
    check("midrst_pass", 32'(test_pass), 32'd0);
    check("midrst_cyc", ReadData, 32'd0);

    // Randomized traffic against the reference model
    rst(1);
    for (int unsigned w = 0; w < DEPTH; w++) begin
      apply(1'b1, 2'b10, 32'(w * 4), $urandom, 1'b0);
      tick();
    end
    for (int n = 0; n < 800; n++) begin
      r = $urandom_range(0, 99);
      a = $urandom_range(0, DEPTH*4 - 1);
      if (r < 35)      apply(1'b1, 2'($urandom_range(0, 3)), a, $urandom, 1'($urandom_range(0, 1)));
      else if (r < 55) apply(1'b0, 2'b10, a, 32'd0, 1'($urandom_range(0, 1)));
      else if (r < 75) apply(1'b1, 2'($urandom_range(0, 3)), CON, $urandom, 1'($urandom_range(0, 3) == 0));
      else if (r < 80) apply(1'b1, 2'b10, STAT, 32'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
      else if (r < 90) apply(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                             CON + 32'($urandom_range(0, 13)), $urandom, 1'($urandom_range(0, 1)));
      else             apply(1'($urandom_range(0, 1)), 2'b10, 32'h1000 + (a & ~32'd3), $urandom, 1'b1);
      check_model($sformatf("rnd%0d", n));
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder end of the single-cycle core's data-memory write/read port: it receives MemWrite/DataAdr/WriteData and returns ReadData.
- Contains a word-organised data RAM and a small MMIO page:
  - a console TX FIFO drained by a valid/ready sink;
  - a sticky test-status register that lets a program report pass/fail in hardware;
  - a free-running cycle counter.
- Sits beside `top`'s imem and replaces the bare dmem.

Parameters:
- DEPTH, 64, RAM depth in 32-bit words; power of 2.
- FIFO_DEPTH, 8, console FIFO entries; power of 2, ≥2.
- MMIO_BASE, 32'hFFFF_0000, base address of the MMIO page; 4 KiB aligned.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous reset, active-high.
- MemWrite  in  1  store strobe for the current cycle.
- MemSize  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved (treated as word).
- DataAdr  in  32  byte address.
- WriteData  in  32  store data, LSB-aligned as delivered by the core.
- ReadData  out  32  combinational read data, always the full aligned word.
- tx_valid  out  1  console byte available.
- tx_data  out  8  console byte, FIFO head.
- tx_ready  in  1  sink accepts the byte when tx_valid & tx_ready at posedge.
- test_done  out  1  program has written TEST_STATUS.
- test_pass  out  1  TEST_STATUS value was exactly 1.
- bus_err  out  1  sticky: misaligned, unmapped or overflowing access seen.

Behaviour:

Reset and clocking:
- Reset is synchronous. Cleared: FIFO pointers/count, test_done, test_pass, bus_err, cycle counter. RAM is not cleared.
- After reset: tx_valid=0; tx_data is don't-care; ReadData is purely combinational.

Address decode:
- RAM: DataAdr < DEPTH*4, word index DataAdr[log2(DEPTH)+1:2].
- MMIO page: DataAdr[31:12]==MMIO_BASE[31:12]. Registers:
  - +0x0 CONSOLE_TX
  - +0x4 TEST_STATUS
  - +0x8 CYCLE_CNT
  - other offsets are unmapped.
- Everything else is unmapped.

Alignment:
- Half access with DataAdr[0]=1 is misaligned.
- Word access with DataAdr[1:0]≠0 is misaligned.
- Misaligned or unmapped write: no state change except bus_err←1 at the next edge.
- Reads never set bus_err. Unmapped reads return 0.

RAM stores:
- Committed at posedge when MemWrite=1, using byte lanes.
- Byte: lane DataAdr[1:0] ← WriteData[7:0].
- Half: lanes {DataAdr[1],0}/+1 ← WriteData[15:0].
- Word: all lanes.
- Read-during-write returns the old word; the new word is visible the next cycle.

CONSOLE_TX:
- Write of any size pushes WriteData[7:0].
- Push is accepted if count<FIFO_DEPTH, or if a pop happens in the same cycle.
- Otherwise the byte is dropped and bus_err←1.
- Read returns {24'b0, count} zero-extended.

FIFO:
- Registered. A byte pushed into an empty FIFO appears on tx_valid/tx_data one cycle later.
- Pop when tx_valid & tx_ready. Simultaneous push and pop leaves count unchanged.
- Pointers wrap modulo FIFO_DEPTH.

TEST_STATUS:
- First write only: test_done←1, test_pass←(WriteData==1).
- Later writes are ignored, so the result stays sticky until reset.
- Read returns {30'b0, test_pass, test_done}.

CYCLE_CNT:
- Increments every cycle after reset; 0 in the first cycle after reset deasserts.
- Wraps from 2^32−1 to 0. Writes are ignored.

Reset mid-operation:
- FIFO contents are discarded; tx_valid drops in the cycle after the reset edge.

Optional Feature:
- DMEM_WRITE_TRACE_EN defined:
  - Every committed RAM or MMIO write prints "<time> ns : Write @ <DataAdr> = <WriteData>" in decimal via $display.
  - Every dropped or erroring write prints "<time> ns : BUS ERROR @ <DataAdr>".
  - Simulation only; the logic is otherwise identical.
- Not defined: no display statements are elaborated.

Test Plan:
1. Reset 3 cycles; word store 7 @100, then read @100 → ReadData=7 next cycle; bus_err=0.
2. Word 0x11223344 @96, byte store 0xAA @97, half store 0xBEEF @98 → read @96 = 0xBEEFAA44.
3. Word store @98 (misaligned) and store @0x1000 (unmapped) → RAM unchanged, bus_err=1 and sticky.
4. Nine CONSOLE_TX writes 'A'..'I' with tx_ready=0:
   - count reads 8, ninth byte dropped, bus_err=1.
   - Raise tx_ready → bytes 'A'..'H' emerge one per cycle, then tx_valid=0.
5. Push while FIFO full and tx_ready=1 in the same cycle → byte accepted, count stays 8, no bus_err.
6. Write 1 to TEST_STATUS, then write 5:
   - test_done=1, test_pass=1 remain.
   - CYCLE_CNT read N cycles after reset equals N−1.
   - Reset mid-run clears everything.
